// File: rtl/cdb_arbiter_if.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | cdb_arbiter_if : FU result ports and CDB broadcast bundle for cdb_arbiter  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface cdb_arbiter_if #(
  parameter int NUM_FU   = 4,
  parameter int PTR_SIZE = 3
);
  localparam int c_src_w = $clog2(NUM_FU);

  logic [NUM_FU-1:0]          fu_valid_in;
  logic [NUM_FU*PTR_SIZE-1:0] fu_rob_ix_in;
  logic [NUM_FU*32-1:0]       fu_value_in;
  logic [NUM_FU-1:0]          fu_ready_out;
  logic                       flush_in;
  logic                       cdb_valid_out;
  logic [PTR_SIZE-1:0]        cdb_rob_ix_out;
  logic [31:0]                cdb_value_out;
  logic [c_src_w-1:0]         cdb_src_out;

  modport master (
    output fu_valid_in, fu_rob_ix_in, fu_value_in, flush_in,
    input  fu_ready_out, cdb_valid_out, cdb_rob_ix_out, cdb_value_out, cdb_src_out
  );

  modport slave (
    input  fu_valid_in, fu_rob_ix_in, fu_value_in, flush_in,
    output fu_ready_out, cdb_valid_out, cdb_rob_ix_out, cdb_value_out, cdb_src_out
  );
endinterface
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | cdb_arbiter : per-FU result FIFOs, round-robin grant onto registered CDB   |
// | Option macro CDB_FIXED_PRI_EN : lane 0 (load unit) always wins if pending  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module cdb_arbiter #(
  parameter int NUM_FU    = 4,
  parameter int PTR_SIZE  = 3,
  parameter int BUF_DEPTH = 2
) (
  input  logic           clk_in,
  input  logic           rst_in,
  cdb_arbiter_if.slave   bus
);
  localparam int c_ptr_w = $clog2(BUF_DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam int c_src_w = $clog2(NUM_FU);
  localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(BUF_DEPTH);
  localparam logic [c_src_w:0]   c_num_fu   = (c_src_w+1)'(NUM_FU);
  localparam logic [c_src_w-1:0] c_last_fu  = c_src_w'(NUM_FU - 1);

  logic [NUM_FU-1:0]   w_empty;
  logic [NUM_FU-1:0]   w_full;
  logic [NUM_FU-1:0]   w_ready;
  logic [PTR_SIZE-1:0] w_head_rob [NUM_FU];
  logic [31:0]         w_head_val [NUM_FU];

  logic [c_src_w-1:0]  r_rr_ptr;
  logic                w_found;
  logic [c_src_w-1:0]  w_grant;
  logic [c_src_w:0]    w_scan;
  logic [c_src_w-1:0]  w_rr_next;
  logic [PTR_SIZE-1:0] w_win_rob;
  logic [31:0]         w_win_val;

  logic                r_cdb_valid;
  logic [PTR_SIZE-1:0] r_cdb_rob;
  logic [31:0]         r_cdb_val;
  logic [c_src_w-1:0]  r_cdb_src;

  // Ready looks only at registered occupancy, so a full FIFO refuses a push even when popped
  assign w_ready          = ~w_full & {NUM_FU{~(rst_in | bus.flush_in)}};
  assign bus.fu_ready_out = w_ready;

  for (genvar k = 0; k < NUM_FU; k++) begin : g_lane
    localparam logic [c_src_w-1:0] c_lane = c_src_w'(k);

    logic [PTR_SIZE-1:0] r_rob_mem [BUF_DEPTH];
    logic [31:0]         r_val_mem [BUF_DEPTH];
    logic [c_ptr_w-1:0]  r_head;
    logic [c_ptr_w-1:0]  r_tail;
    logic [c_cnt_w-1:0]  r_count;
    logic                w_push;
    logic                w_pop;

    assign w_full[k]     = (r_count == c_full_cnt);
    assign w_empty[k]    = (r_count == '0);
    assign w_push        = bus.fu_valid_in[k] && w_ready[k];
    assign w_pop         = w_found && (w_grant == c_lane);
    assign w_head_rob[k] = r_rob_mem[r_head];
    assign w_head_val[k] = r_val_mem[r_head];

    always_ff @(posedge clk_in) begin
      if (rst_in || bus.flush_in) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) r_tail <= r_tail + c_ptr_w'(1);
        if (w_pop)  r_head <= r_head + c_ptr_w'(1);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + c_cnt_w'(1);
          2'b01:   r_count <= r_count - c_cnt_w'(1);
          default: r_count <= r_count;
        endcase
      end
    end

    always_ff @(posedge clk_in) begin
      if (w_push) begin
        r_rob_mem[r_tail] <= bus.fu_rob_ix_in[k*PTR_SIZE +: PTR_SIZE];
        r_val_mem[r_tail] <= bus.fu_value_in[k*32 +: 32];
      end
    end
  end

  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_scan  = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      w_scan = {1'b0, r_rr_ptr} + (c_src_w+1)'(i);
      if (w_scan >= c_num_fu) w_scan = w_scan - c_num_fu;
      if (!w_found && !w_empty[w_scan[c_src_w-1:0]]) begin
        w_found = 1'b1;
        w_grant = w_scan[c_src_w-1:0];
      end
    end
`ifdef CDB_FIXED_PRI_EN
    if (!w_empty[0]) begin
      w_found = 1'b1;
      w_grant = '0;
    end
`endif
  end

  assign w_rr_next = (w_grant == c_last_fu) ? '0 : w_grant + c_src_w'(1);

  always_comb begin
    w_win_rob = '0;
    w_win_val = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      if (w_grant == c_src_w'(k)) begin
        w_win_rob = w_head_rob[k];
        w_win_val = w_head_val[k];
      end
    end
  end

  // Data outputs hold their last broadcast when nothing wins; only reset clears them
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_cdb_valid <= 1'b0;
      r_cdb_rob   <= '0;
      r_cdb_val   <= '0;
      r_cdb_src   <= '0;
      r_rr_ptr    <= '0;
    end else if (bus.flush_in) begin
      r_cdb_valid <= 1'b0;
      r_rr_ptr    <= '0;
    end else if (w_found) begin
      r_cdb_valid <= 1'b1;
      r_cdb_rob   <= w_win_rob;
      r_cdb_val   <= w_win_val;
      r_cdb_src   <= w_grant;
      r_rr_ptr    <= w_rr_next;
    end else begin
      r_cdb_valid <= 1'b0;
    end
  end

  assign bus.cdb_valid_out  = r_cdb_valid;
  assign bus.cdb_rob_ix_out = r_cdb_rob;
  assign bus.cdb_value_out  = r_cdb_val;
  assign bus.cdb_src_out    = r_cdb_src;
endmodule
`default_nettype wire

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
Arbitrates completed results from NUM_FU functional units onto the single common data bus (CDB). The CDB broadcasts results to the reservation stations and the ROB.
- Each FU pushes {rob_ix, value} into a private result FIFO.
- One head entry per cycle is granted round-robin and driven onto registered CDB outputs.
- Sits between FU result ports and every CDB consumer.

Parameters:
NUM_FU, 4, number of requesting functional units (2..8)
PTR_SIZE, 3, ROB index width
BUF_DEPTH, 2, entries per per-FU result FIFO (power of two, >=2)

Ports:
clk_in  input  1  clock
rst_in  input  1  synchronous active-high reset
fu_valid_in  input  NUM_FU  per-FU result valid
fu_rob_ix_in  input  NUM_FU*PTR_SIZE  packed ROB indices, lane k at [k*PTR_SIZE +: PTR_SIZE]
fu_value_in  input  NUM_FU*32  packed signed results, lane k at [k*32 +: 32]
fu_ready_out  output  NUM_FU  per-FU FIFO can accept
flush_in  input  1  pipeline flush (mispredict)
cdb_valid_out  output  1  CDB broadcast valid
cdb_rob_ix_out  output  PTR_SIZE  broadcast ROB index
cdb_value_out  output  32  broadcast signed value
cdb_src_out  output  $clog2(NUM_FU)  lane that won the grant

Behaviour:
- Clock is clk_in. Reset is rst_in, synchronous and active-high.
- Reset values:
  - cdb_valid_out=0, cdb_rob_ix_out=0, cdb_value_out=0, cdb_src_out=0.
  - All FIFOs empty; rr_ptr=0.
- fu_ready_out[k]:
  - Combinational: = !full[k] && !rst_in && !flush_in.
  - Must not depend on fu_valid_in.
  - Full is evaluated before the same-cycle pop, so a full FIFO refuses a push even in a cycle where it is popped.
- Push: on the edge where fu_valid_in[k] && fu_ready_out[k], lane k's rob_ix/value are written at tail[k]. Valid while not ready means the result is not taken; the FU holds it.
- Grant, each cycle (combinational, from registered FIFO state only):
  - Scan lanes rr_ptr, rr_ptr+1, ... mod NUM_FU.
  - The first non-empty lane g wins. The head of lane g is popped at the edge.
  - Registered outputs at that edge: cdb_valid_out=1, cdb_rob_ix_out/value_out=head of g, cdb_src_out=g.
  - rr_ptr <= (g+1) mod NUM_FU.
- No winner: cdb_valid_out<=0; rob_ix/value/src hold their previous values; rr_ptr unchanged.
- Latency:
  - A result accepted at edge t is in the FIFO after t.
  - The earliest it can appear on the CDB is after edge t+1.
  - There is no bypass from input to CDB.
- Throughput: exactly one broadcast per cycle maximum. There is no CDB backpressure; consumers always accept.
- Simultaneous push and pop on the same lane (not full): both happen; occupancy is unchanged.
- FIFO pointers are log2(BUF_DEPTH) bits and wrap naturally. The count is log2(BUF_DEPTH)+1 bits.
- Flush:
  - On an edge with flush_in=1, all FIFOs are emptied, rr_ptr<=0 and cdb_valid_out<=0.
  - Pushes in that cycle are dropped, since ready is forced to 0.
  - No pop is broadcast in that cycle.
- Reset asserted mid-operation: same clearing as flush, plus the data outputs are zeroed.
- Per-lane ordering is preserved (FIFO). Relative order across lanes is defined only by the grant rule.

Optional Feature:
CDB_FIXED_PRI_EN
- Defined: lane 0 (load unit) wins whenever its FIFO is non-empty, regardless of rr_ptr. rr_ptr still updates to (g+1) mod NUM_FU after every grant, including lane-0 grants. The other lanes rotate round-robin as normal.
- Undefined: pure round-robin as described in Behaviour.

Test Plan:
- Reset, then lane 2 pushes rob_ix=5, value=-7 at edge 1 → cdb_valid_out=1, rob_ix=5, value=-7, src=2 after edge 2; cdb_valid_out=0 after edge 3.
- All 4 lanes push in the same cycle with rob_ix 0..3 → CDB shows src 0,1,2,3 on four consecutive cycles, then valid=0.
- Lanes 0 and 2 push continuously every cycle they are ready → grants alternate 0,2,0,2; each lane gets exactly 50% over 20 cycles; no starvation.
- BUF_DEPTH=2, lane 1 pushes 3 consecutive cycles while lanes 0, 2 and 3 saturate → fu_ready_out[1]=0 once 2 entries are held; the third result is accepted only after a lane-1 grant; no loss or duplication.
- Fill lanes 0 and 3 with 2 entries each, then assert flush_in for 1 cycle → cdb_valid_out=0 the next cycle; no stale entry is ever broadcast; a new lane-3 push after the flush appears with src=3 two edges later.
- With CDB_FIXED_PRI_EN defined, lanes 0 and 1 are both continuously non-empty → every grant is src=0 until lane 0 drains, then lane 1 is served. Without the macro, grants alternate.
